// File: rtl/ifetch_unit.sv
// Instruction fetch front end: fetch PC, credit-limited memory requests and an in-order prefetch FIFO.
// Optional macro IFETCH_NOOP_BUBBLE_EN presents a NOOP bubble (16'hBF00) to decode while the FIFO is empty.
module ifetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic              imem_valid_i,
  input  logic [15:0]       imem_data_i,
  output logic [15:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic              bubble_o
);

  localparam int                PW      = $clog2(FIFO_DEPTH);
  localparam int                CW      = PW + 1;
  localparam logic [CW:0]       DEPTH_W = FIFO_DEPTH[CW:0];
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(1);

  logic [15:0]       r_fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_discard;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;

  logic              w_empty;
  logic              w_accept;
  logic              w_live_resp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic [CW:0]       w_credit;
  logic [CW-1:0]     w_inflight_nxt;
  logic [CW:0]       w_discard_redir;
  logic [ADDR_W-1:0] w_target;

  assign w_empty     = (r_count == '0);
  assign w_credit    = {1'b0, r_count} + {1'b0, r_inflight};
  assign imem_req_o  = !reset_i && !halt_i && !redirect_i && (w_credit < DEPTH_W);
  assign imem_addr_o = r_fetch_pc;
  assign w_accept    = imem_req_o && imem_ready_i;
  assign w_live_resp = imem_valid_i && (r_discard == '0);
  assign w_drop      = imem_valid_i && (r_discard != '0);
  assign w_push      = w_live_resp && !redirect_i && !reset_i;
  assign w_pop       = !w_empty && instr_ready_i;
  assign w_target    = redirect_pc_i & PC_MASK;

  assign w_inflight_nxt  = r_inflight + CW'(w_accept) - CW'(w_live_resp);
  // On redirect every response still owed (live or already doomed) must be discarded.
  assign w_discard_redir = {1'b0, w_inflight_nxt} + {1'b0, r_discard} - (CW+1)'(w_drop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= w_target;
      r_resp_pc  <= w_target;
      r_inflight <= '0;
      r_discard  <= w_discard_redir[CW-1:0];
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
      r_inflight <= w_inflight_nxt;
      r_discard  <= r_discard - CW'(w_drop);
      // Live responses since the last redirect are sequential, so their PCs follow a running counter.
      if (w_push) begin
        r_resp_pc <= r_resp_pc + PC_STEP;
        r_wr_ptr  <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_data_i;
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

`ifdef IFETCH_NOOP_BUBBLE_EN
  always_comb begin
    bubble_o      = !reset_i && w_empty;
    instr_valid_o = !reset_i;
    instr_o       = r_fifo_instr[r_rd_ptr];
    instr_pc_o    = r_fifo_pc[r_rd_ptr];
    if (w_empty) begin
      instr_o    = 16'hBF00;
      instr_pc_o = r_resp_pc;
    end
  end
`else
  always_comb begin
    bubble_o      = 1'b0;
    instr_valid_o = !reset_i && !w_empty;
    instr_o       = r_fifo_instr[r_rd_ptr];
    instr_pc_o    = r_fifo_pc[r_rd_ptr];
  end
`endif

  a_resp_has_request: assert property (@(posedge clk_i) disable iff (reset_i)
    imem_valid_i |-> (r_inflight != '0 || r_discard != '0));

  a_discard_fits: assert property (@(posedge clk_i) disable iff (reset_i)
    redirect_i |-> !w_discard_redir[CW]);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit with a small in-order instruction memory model.
module tb_ifetch_unit;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ready_i = 1'b1;
  logic        imem_valid_i = 1'b0;
  logic [15:0] imem_data_i = 16'h0000;
  logic [15:0] instr_o;
  logic [15:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = 16'h0000;
  logic        halt_i = 1'b0;
  logic        bubble_o;
  logic        mem_en = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  ifetch_unit #(.ADDR_W(16), .FIFO_DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .halt_i(halt_i), .bubble_o(bubble_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h2005;
      16'h0002: return 16'h2106;
      16'h0004: return 16'h1888;
      default:  return 16'hE000 | a;
    endcase
  endfunction

  // memory: responds in order one cycle after acceptance while mem_en is high
  logic [15:0] mq[$];
  logic        m_acc = 1'b0;
  logic        m_rsp = 1'b0;
  logic        m_rst = 1'b1;
  logic [15:0] m_addr = 16'h0000;

  always @(negedge clk_i) begin
    m_rst  = reset_i;
    m_acc  = imem_req_o && imem_ready_i;
    m_rsp  = imem_valid_i;
    m_addr = imem_addr_o;
  end

  always @(posedge clk_i) begin
    #2;
    if (m_rst) mq.delete();
    else begin
      if (m_rsp && mq.size() > 0) void'(mq.pop_front());
      if (m_acc) mq.push_back(m_addr);
    end
    imem_valid_i = mem_en && (mq.size() > 0);
    imem_data_i  = imem_valid_i ? mem_word(mq[0]) : 16'h0000;
  end

  typedef struct {
    logic        rst, rdr;
    logic [15:0] rpc;
    logic        halt, drdy, men;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] ins, pc;
    logic        bchk;
  } vec_t;

  function automatic vec_t V(input logic rst, rdr, input logic [15:0] rpc,
                             input logic halt, drdy, men, req, input logic [15:0] addr,
                             input logic vld, input logic [15:0] ins, pc, input logic bchk);
    vec_t r;
    r.rst = rst; r.rdr = rdr; r.rpc = rpc; r.halt = halt; r.drdy = drdy; r.men = men;
    r.req = req; r.addr = addr; r.vld = vld; r.ins = ins; r.pc = pc; r.bchk = bchk;
    return r;
  endfunction

  task automatic chk(input int idx, input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk_i);
    #1;
    reset_i = v.rst; redirect_i = v.rdr; redirect_pc_i = v.rpc;
    halt_i = v.halt; instr_ready_i = v.drdy; mem_en = v.men;
    @(negedge clk_i);
    n_vec++;
    chk(idx, "req", 16'(imem_req_o), 16'(v.req));
    chk(idx, "addr", imem_addr_o, v.addr);
`ifdef IFETCH_NOOP_BUBBLE_EN
    if (!v.rst && !v.vld) begin
      chk(idx, "valid", 16'(instr_valid_o), 16'h0001);
      chk(idx, "bubble", 16'(bubble_o), 16'h0001);
      chk(idx, "instr", instr_o, 16'hBF00);
      if (v.bchk) chk(idx, "bubble_pc", instr_pc_o, v.pc);
    end else begin
`else
    begin
`endif
      chk(idx, "valid", 16'(instr_valid_o), 16'(v.vld));
      chk(idx, "bubble", 16'(bubble_o), 16'h0000);
      if (v.vld) begin
        chk(idx, "instr", instr_o, v.ins);
        chk(idx, "pc", instr_pc_o, v.pc);
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    // rst rdr rpc halt drdy men | req addr vld instr pc bchk
    // reset, then sequential fetch of 0x0/0x2/0x4
    tbl.push_back(V(1,0,16'h0000,0,1,1, 0,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0002,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 0,16'h0004,1,16'h2005,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0004,1,16'h2106,16'h0002,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0006,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 0,16'h0008,1,16'h1888,16'h0004,0));
    // mid-run reset, then 10-cycle decode stall
    tbl.push_back(V(1,0,16'h0000,0,1,1, 0,16'h0008,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,0,1, 1,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,0,1, 1,16'h0002,0,16'h0000,16'h0000,0));
    for (int k = 10; k <= 17; k++)
      tbl.push_back(V(0,0,16'h0000,0,0,1, 0,16'h0004,1,16'h2005,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 0,16'h0004,1,16'h2005,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0004,1,16'h2106,16'h0002,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0006,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 0,16'h0008,1,16'h1888,16'h0004,0));
    // two requests held in flight, redirect to 0x0041
    tbl.push_back(V(0,0,16'h0000,0,1,0, 1,16'h0008,1,16'hE006,16'h0006,0));
    tbl.push_back(V(0,0,16'h0000,0,1,0, 1,16'h000A,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,1,16'h0041,0,1,0, 0,16'h000C,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0040,0,16'h0000,16'h0040,1));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0042,0,16'h0000,16'h0040,1));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 0,16'h0044,0,16'h0000,16'h0040,1));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 0,16'h0044,1,16'hE040,16'h0040,0));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0044,1,16'hE042,16'h0042,0));
    // halt for 5 cycles with one request outstanding
    tbl.push_back(V(0,0,16'h0000,1,1,0, 0,16'h0046,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,1,1,1, 0,16'h0046,0,16'h0000,16'h0000,0));
    tbl.push_back(V(0,0,16'h0000,1,1,1, 0,16'h0046,1,16'hE044,16'h0044,0));
    tbl.push_back(V(0,0,16'h0000,1,1,1, 0,16'h0046,0,16'h0000,16'h0046,1));
    tbl.push_back(V(0,0,16'h0000,1,1,1, 0,16'h0046,0,16'h0000,16'h0046,1));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0046,0,16'h0000,16'h0046,1));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 1,16'h0048,0,16'h0000,16'h0046,1));
    tbl.push_back(V(0,0,16'h0000,0,1,1, 0,16'h004A,1,16'hE046,16'h0046,0));

    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // redirect in the same cycle as a live response and a pop
    apply(V(0,0,16'h0000,0,0,0, 1,16'h004A,1,16'hE048,16'h0048,0), 38);
    apply(V(0,1,16'h0100,0,1,1, 0,16'h004C,1,16'hE048,16'h0048,0), 39);
    apply(V(0,0,16'h0000,0,1,1, 1,16'h0100,0,16'h0000,16'h0100,1), 40);
    apply(V(0,0,16'h0000,0,1,1, 1,16'h0102,0,16'h0000,16'h0100,1), 41);
    // back-to-back redirects with an issue in between: two responses discarded
    apply(V(0,1,16'h0200,0,1,0, 0,16'h0104,1,16'hE100,16'h0100,0), 42);
    apply(V(0,0,16'h0000,0,1,0, 1,16'h0200,0,16'h0000,16'h0200,1), 43);
    apply(V(0,1,16'h0301,0,1,0, 0,16'h0202,0,16'h0000,16'h0200,1), 44);
    apply(V(0,0,16'h0000,0,1,1, 1,16'h0300,0,16'h0000,16'h0300,1), 45);
    apply(V(0,0,16'h0000,0,1,1, 1,16'h0302,0,16'h0000,16'h0300,1), 46);
    apply(V(0,0,16'h0000,0,1,1, 0,16'h0304,0,16'h0000,16'h0300,1), 47);
    // redirect to 0xFFFF lands on 0xFFFE, then sequential wrap to 0x0000
    apply(V(0,1,16'hFFFF,0,1,1, 0,16'h0304,1,16'hE300,16'h0300,0), 48);
    apply(V(0,0,16'h0000,0,1,1, 1,16'hFFFE,0,16'h0000,16'hFFFE,1), 49);
    apply(V(0,0,16'h0000,0,1,1, 1,16'h0000,0,16'h0000,16'hFFFE,1), 50);
    apply(V(0,0,16'h0000,0,1,1, 0,16'h0002,1,16'hFFFE,16'hFFFE,0), 51);
    apply(V(0,0,16'h0000,0,1,1, 1,16'h0002,1,16'h2005,16'h0000,0), 52);
    // memory stops responding: FIFO drains and stays empty
    apply(V(0,0,16'h0000,0,1,0, 1,16'h0004,0,16'h0000,16'h0002,1), 53);
    for (int k = 54; k <= 57; k++)
      apply(V(0,0,16'h0000,0,1,0, 0,16'h0006,0,16'h0000,16'h0002,1), k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
